// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains in ascending order once lock_in is stable.
// Latency: LOCK_STABLE cycles to first release, then >= STAGE_DELAY cycles per stage; all outputs registered.
// No backpressure: stage_ack gates each advance; ack timeouts restart up to MAX_RETRIES, then halt in FAILED.

module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int LOCK_STABLE = 1000,
  parameter int STAGE_DELAY = 1000,
  parameter int ACK_TIMEOUT = 100000,
  parameter int MAX_RETRIES = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  lock_in,
  input  logic                  sw_reset,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  seq_done,
  output logic                  seq_fail,
  output logic [3:0]            retry_count,
  output logic [1:0]            state_out
);

  // State encoding is visible on state_out and must stay fixed.
  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_STAGE     = 2'd1;
  localparam logic [1:0] S_DONE      = 2'd2;
  localparam logic [1:0] S_FAILED    = 2'd3;

  localparam int LW = $clog2(LOCK_STABLE) + 1;
  localparam int DW = $clog2(ACK_TIMEOUT) + 1;
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // Thresholds are compared against the pre-edge counter value, hence the "-1" forms.
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_STABLE - 1);
  localparam logic [LW-1:0] LOCK_MAX     = LW'(LOCK_STABLE);
  localparam logic [DW-1:0] DELAY_LAST   = DW'(STAGE_DELAY - 1);
  localparam logic [DW-1:0] TIMEOUT_LAST = DW'(ACK_TIMEOUT - 1);
  localparam logic [DW-1:0] DWELL_MAX    = DW'(ACK_TIMEOUT);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);
  localparam logic [KW-1:0] K_LAST       = KW'(NUM_STAGES - 1);

  logic                  rst_sync_q;
  logic [1:0]            state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [NUM_STAGES-1:0] rst_d;
  logic [3:0]            retry_d;
  logic                  done_d;
  logic                  fail_d;
  logic                  go_wait;

  // Stages 0..idx released, everything above still held in reset.
  function automatic logic [NUM_STAGES-1:0] therm(input logic [KW-1:0] idx);
    logic [NUM_STAGES-1:0] m;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (i <= int'(idx));
    end
    return m;
  endfunction

  // Register resetn release once; state only starts moving the edge after this flop sets.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  // Next-state logic; priority is sw_reset, then lock loss, then timeout, then advance.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    dwell_d    = dwell_q;
    rst_d      = stage_resetn;
    retry_d    = retry_count;
    done_d     = seq_done;
    fail_d     = seq_fail;
    go_wait    = 1'b0;
    lock_cnt_d = lock_cnt_q;

    // Stability counter: any low cycle clears it, saturates at LOCK_STABLE.
    if (!lock_in) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q < LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end

    if (sw_reset) begin
      go_wait = 1'b1;
      retry_d = '0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          rst_d = '0;
          if (lock_in && (lock_cnt_q >= LOCK_LAST)) begin
            state_d = S_STAGE;
            k_d     = '0;
            dwell_d = '0;
            rst_d   = therm('0);
          end
        end

        S_STAGE: begin
          if (dwell_q < DWELL_MAX) begin
            dwell_d = dwell_q + 1'b1;
          end
          if (!lock_in) begin
            go_wait = 1'b1;
          end else if (dwell_q >= TIMEOUT_LAST) begin
            if (retry_count < RETRY_MAX) begin
              go_wait = 1'b1;
              retry_d = retry_count + 1'b1;
            end else begin
              state_d    = S_FAILED;
              k_d        = '0;
              dwell_d    = '0;
              lock_cnt_d = '0;
              rst_d      = '0;
              done_d     = 1'b0;
              fail_d     = 1'b1;
            end
          end else if ((dwell_q >= DELAY_LAST) && stage_ack[k_q]) begin
            if (k_q == K_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              k_d     = k_q + 1'b1;
              dwell_d = '0;
              rst_d   = therm(k_q + 1'b1);
            end
          end
        end

        S_DONE: begin
          if (!lock_in) begin
            go_wait = 1'b1;
          end
        end

        default: begin
          // FAILED is sticky: lock_in and stage_ack are ignored here.
          rst_d  = '0;
          done_d = 1'b0;
          fail_d = 1'b1;
        end
      endcase
    end

    // Every path back to WAIT_LOCK reasserts all stage resets together.
    if (go_wait) begin
      state_d    = S_WAIT_LOCK;
      k_d        = '0;
      lock_cnt_d = '0;
      dwell_d    = '0;
      rst_d      = '0;
      done_d     = 1'b0;
      fail_d     = 1'b0;
    end
  end

  // State registers; resetn asserts asynchronously, updates wait for the registered release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_WAIT_LOCK;
      k_q          <= '0;
      lock_cnt_q   <= '0;
      dwell_q      <= '0;
      stage_resetn <= '0;
      retry_count  <= '0;
      seq_done     <= 1'b0;
      seq_fail     <= 1'b0;
    end else if (rst_sync_q) begin
      state_q      <= state_d;
      k_q          <= k_d;
      lock_cnt_q   <= lock_cnt_d;
      dwell_q      <= dwell_d;
      stage_resetn <= rst_d;
      retry_count  <= retry_d;
      seq_done     <= done_d;
      seq_fail     <= fail_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: drives directed and random lock/ack/sw_reset/resetn patterns into reset_sequencer.
// Expected outputs come from an edge-stepped model of the sequencing rules (released-stage count, mode, counters).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.

module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int LS = 4;
  localparam int SD = 2;
  localparam int AT = 10;
  localparam int MR = 2;

  localparam int M_WAIT  = 0;
  localparam int M_STAGE = 1;
  localparam int M_DONE  = 2;
  localparam int M_FAIL  = 3;

  logic         clock = 1'b0;
  logic         resetn;
  logic         lock_in;
  logic         sw_reset;
  logic [N-1:0] stage_ack;
  logic [N-1:0] stage_resetn;
  logic         seq_done;
  logic         seq_fail;
  logic [3:0]   retry_count;
  logic [1:0]   state_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: mode, number of released stages, edges since last stage entry.
  int m_mode;
  int m_rel;
  int m_lock_run;
  int m_since;
  int m_retries;
  bit m_armed;

  always #5 clock = ~clock;

  reset_sequencer #(
    .NUM_STAGES (N),
    .LOCK_STABLE(LS),
    .STAGE_DELAY(SD),
    .ACK_TIMEOUT(AT),
    .MAX_RETRIES(MR)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .lock_in     (lock_in),
    .sw_reset    (sw_reset),
    .stage_ack   (stage_ack),
    .stage_resetn(stage_resetn),
    .seq_done    (seq_done),
    .seq_fail    (seq_fail),
    .retry_count (retry_count),
    .state_out   (state_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_to_wait();
    m_mode     = M_WAIT;
    m_rel      = 0;
    m_lock_run = 0;
    m_since    = 0;
  endtask

  task automatic model_reset();
    model_to_wait();
    m_retries = 0;
    m_armed   = 1'b0;
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_step(input bit lock, input bit sw, input logic [N-1:0] ack);
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (sw) begin
      model_to_wait();
      m_retries = 0;
    end else begin
      case (m_mode)
        M_WAIT: begin
          m_lock_run = lock ? m_lock_run + 1 : 0;
          if (m_lock_run == LS) begin
            m_mode  = M_STAGE;
            m_rel   = 1;
            m_since = 0;
          end
        end
        M_STAGE: begin
          m_since++;
          if (!lock) begin
            model_to_wait();
          end else if (m_since == AT) begin
            if (m_retries < MR) begin
              m_retries++;
              model_to_wait();
            end else begin
              model_to_wait();
              m_mode = M_FAIL;
            end
          end else if (m_since >= SD && ack[m_rel-1]) begin
            if (m_rel == N) begin
              m_mode = M_DONE;
            end else begin
              m_rel++;
              m_since = 0;
            end
          end
        end
        M_DONE: begin
          if (!lock) model_to_wait();
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":stage_resetn"}, 32'(stage_resetn), 32'((1 << m_rel) - 1));
    check({tag, ":seq_done"},     32'(seq_done),     32'(m_mode == M_DONE));
    check({tag, ":seq_fail"},     32'(seq_fail),     32'(m_mode == M_FAIL));
    check({tag, ":retry_count"},  32'(retry_count),  32'(m_retries));
    check({tag, ":state_out"},    32'(state_out),    32'(m_mode));
  endtask

  task automatic tick(input bit lock, input bit sw, input logic [N-1:0] ack, input string tag);
    lock_in   = lock;
    sw_reset  = sw;
    stage_ack = ack;
    @(posedge clock);
    model_step(lock, sw, ack);
    #1;
    check_outputs(tag);
  endtask

  // Outputs must clear before any clock edge; release is left one unit after an edge.
  task automatic apply_reset(input string tag);
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs({tag, ":async"});
    @(posedge clock);
    #1;
    check_outputs({tag, ":held"});
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    logic [N-1:0] mask;
    resetn    = 1'b1;
    lock_in   = 1'b0;
    sw_reset  = 1'b0;
    stage_ack = '0;
    #3;
    apply_reset("por");

    // Clean sequence with all acks high.
    tick(1'b0, 1'b0, 3'b000, "arm");
    n = 0;
    do begin tick(1'b1, 1'b0, 3'b111, "seq"); n++; end while (seq_done !== 1'b1 && n < 40);
    check("seq_done_latency", 32'(n), 32'd10);
    check("seq_final_rst", 32'(stage_resetn), 32'h7);
    check("seq_final_state", 32'(state_out), 32'd2);

    // Lock loss in DONE, then relock.
    tick(1'b0, 1'b0, 3'b111, "lockloss");
    check("lockloss_rst", 32'(stage_resetn), 32'd0);
    n = 0;
    do begin tick(1'b1, 1'b0, 3'b111, "relock"); n++; end while (stage_resetn[0] !== 1'b1 && n < 20);
    check("relock_latency", 32'(n), 32'd4);

    // Lock glitch on the third stable cycle restarts the count.
    tick(1'b1, 1'b1, 3'b111, "sw");
    tick(1'b1, 1'b0, 3'b111, "lock1");
    tick(1'b1, 1'b0, 3'b111, "lock2");
    tick(1'b0, 1'b0, 3'b111, "glitch");
    n = 0;
    do begin tick(1'b1, 1'b0, 3'b111, "postglitch"); n++; end while (stage_resetn[0] !== 1'b1 && n < 20);
    check("glitch_latency", 32'(n), 32'd4);

    // Stage 1 never acknowledges: two retries, then FAILED.
    tick(1'b1, 1'b1, 3'b101, "sw");
    n = 0;
    do begin tick(1'b1, 1'b0, 3'b101, "to1"); n++; end while (retry_count !== 4'd1 && n < 40);
    check("timeout1_latency", 32'(n), 32'd16);
    n = 0;
    do begin tick(1'b1, 1'b0, 3'b101, "to23"); n++; end while (state_out !== 2'd3 && n < 60);
    check("fail_latency", 32'(n), 32'd32);
    check("fail_retry", 32'(retry_count), 32'd2);
    check("fail_flag", 32'(seq_fail), 32'd1);

    // FAILED ignores lock and ack; sw_reset recovers.
    for (int i = 0; i < 8; i++) tick(i[0], 1'b0, 3'($urandom_range(0, 7)), "failhold");
    tick(1'b1, 1'b1, 3'b111, "sw_fail");
    check("sw_fail_state", 32'(state_out), 32'd0);
    n = 0;
    do begin tick(1'b1, 1'b0, 3'b111, "recover"); n++; end while (seq_done !== 1'b1 && n < 40);
    check("recover_latency", 32'(n), 32'd10);

    // sw_reset, lock loss and ack together mid-STAGE, with a nonzero retry count.
    tick(1'b1, 1'b1, 3'b101, "sw");
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 3'b101, "to_once");
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 3'b111, "enter");
    check("pre_triple_retry", 32'(retry_count), 32'd1);
    tick(1'b0, 1'b1, 3'b111, "triple");
    check("triple_retry", 32'(retry_count), 32'd0);

    // resetn pulse mid-STAGE.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 3'b000, "enter2");
    check("pre_rst_state", 32'(state_out), 32'd1);
    apply_reset("mid_stage");

    // Random traffic with sticky ack masks so timeouts and failures occur.
    mask = '1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) mask = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      if ($urandom_range(0, 999) == 0) begin
        apply_reset("rnd_rst");
      end else begin
        tick($urandom_range(0, 59) != 0, $urandom_range(0, 399) == 0,
             3'($urandom_range(0, 7) | $urandom_range(0, 7)) & mask, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of sequenced reset domains, legal range 1..8.
REQ-002 Parameter LOCK_STABLE, default 1000: consecutive cycles lock_in must be high before sequencing starts, >=1.
REQ-003 Parameter STAGE_DELAY, default 1000: minimum cycles a stage is out of reset before the next stage may release, >=1.
REQ-004 Parameter ACK_TIMEOUT, default 100000: cycles allowed for a stage acknowledge, SHALL exceed STAGE_DELAY.
REQ-005 Parameter MAX_RETRIES, default 3: timeout restarts permitted before giving up, range 0..15.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 lock_in  input  1  upstream clock/PLL locked, active high, synchronous to clock.
REQ-009 sw_reset  input  1  single-cycle software request to restart the whole sequence.
REQ-010 stage_ack  input  NUM_STAGES  per-stage "domain alive" acknowledge, bit k for stage k.
REQ-011 stage_resetn  output  NUM_STAGES  per-stage active-low reset, each bit registered.
REQ-012 seq_done  output  1  all stages released and acknowledged.
REQ-013 seq_fail  output  1  retries exhausted; sequencer halted.
REQ-014 retry_count  output  4  timeout restarts since last resetn/sw_reset.
REQ-015 state_out  output  2  current state encoding: WAIT_LOCK=0, STAGE=1, DONE=2, FAILED=3.

Function
REQ-016 Four states: WAIT_LOCK, STAGE, DONE, FAILED; stage index k (0..NUM_STAGES-1) held in STAGE.
REQ-017 WAIT_LOCK: all stage_resetn low; stability counter increments while lock_in high, clears to 0 on any cycle lock_in low.
REQ-018 WAIT_LOCK exit: on the edge where the counter reaches LOCK_STABLE, go to STAGE with k=0 and stage_resetn[0] high from that edge.
REQ-019 STAGE: dwell counter cleared on every stage entry (edge E, when stage_resetn[k] rises), incremented each cycle after.
REQ-020 Advance: earliest at edge E+STAGE_DELAY, first edge at or after it where stage_ack[k] sampled high; stage_resetn[k+1] rises on that edge; stage_ack is ignored before E+STAGE_DELAY.
REQ-021 Last stage advance goes to DONE; seq_done high from that edge; released stages stay high.
REQ-022 Timeout: if no advance by edge E+ACK_TIMEOUT, all stage_resetn low on that edge; if retry_count < MAX_RETRIES, retry_count increments and state becomes WAIT_LOCK (stability counter 0), else state becomes FAILED with retry_count unchanged.
REQ-023 FAILED: all stage_resetn low, seq_fail high; lock_in and stage_ack ignored; exit only via sw_reset or resetn.
REQ-024 Lock loss: lock_in low while in STAGE or DONE drives all stage_resetn low on the next edge and enters WAIT_LOCK; retry_count unchanged; seq_done low.
REQ-025 sw_reset high in any state: on next edge all stage_resetn low, retry_count=0, stability counter 0, state WAIT_LOCK, seq_done/seq_fail low.
REQ-026 Priority, same cycle: sw_reset > lock loss > timeout > advance.
REQ-027 Stages release strictly in ascending index order; stage_resetn bits never deassert out of order; all bits reassert together.
REQ-028 Counters sized $clog2(max value)+1 bits; no wrap: stability counter saturates at LOCK_STABLE, dwell counter stops at ACK_TIMEOUT.
REQ-029 seq_done and seq_fail are registered and mutually exclusive.

Reset
REQ-030 resetn low asynchronously forces: stage_resetn all 0, seq_done 0, seq_fail 0, retry_count 0, all counters 0, state WAIT_LOCK, k=0.
REQ-031 resetn deassertion is synchronized internally; first state update on the second rising edge after release.
REQ-032 resetn asserted mid-sequence immediately reasserts every stage reset regardless of state.

Verification (NUM_STAGES=3, LOCK_STABLE=4, STAGE_DELAY=2, ACK_TIMEOUT=10, MAX_RETRIES=2)
REQ-033 lock_in high, stage_ack tied 3'b111 -> stage_resetn 000->001 after 4 lock cycles, ->011 two cycles later, ->111 two cycles later, seq_done=1, state_out=2.
REQ-034 lock_in glitches low at cycle 3 of stability -> counter restarts, stage_resetn[0] rises exactly 4 cycles after lock_in returns high.
REQ-035 stage_ack[1] never asserts -> timeout 10 cycles after stage 1 release, stage_resetn=000, retry_count=1; repeat -> 2; third timeout -> state_out=3, seq_fail=1, retry_count=2.
REQ-036 lock_in drops in DONE -> next edge stage_resetn=000, seq_done=0, state_out=0, retry_count unchanged; resequences after 4 stable cycles.
REQ-037 sw_reset pulse in FAILED -> retry_count=0, seq_fail=0, state_out=0, normal sequence follows.
REQ-038 sw_reset, lock loss and stage_ack all in one cycle -> sw_reset effects only; resetn pulsed mid-STAGE -> outputs 0 asynchronously, before next clock edge.
